alu_sequencer: RTL and testbench
================================

# alu_sequencer

Execute-stage controller that drives the external combinational ALU from the operand side and consumes its outputs. It accepts one ALU instruction at a time over a valid/ready handshake and reads the second operand from a small internal register file. It presents the W accumulator and that operand to the ALU, then captures the ALU result into W and latches the carry/zero flags. It sits between instruction decode and the ALU in the 8-bit computer datapath.

## Interface
- NREGS, 4, number of 8-bit general registers in the internal register file.
- RIDX_W, 2, register index width; must equal clog2(NREGS).

- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- instr_valid  in  1  instruction offered.
- instr_ready  out  1  sequencer can accept an instruction this cycle.
- instr_op  in  3  ALU opcode, passed to ALU_OP.
- instr_rn  in  RIDX_W  register index of the second operand.
- instr_wb  in  1  1: write the result to W; 0: update flags only (compare/test).
- rf_we  in  1  register file write strobe.
- rf_waddr  in  RIDX_W  register file write index.
- rf_wdata  in  8  register file write data.
- w_load  in  1  load W directly from w_data.
- w_data  in  8  direct W load value.
- Wreg_w  out  8  ALU operand A, registered.
- Rn_w  out  8  ALU operand B, registered.
- ALU_OP  out  3  ALU opcode, registered.
- ALUResult_w  in  8  ALU result.
- carryF_w  in  1  ALU carry/borrow flag.
- zeroF_w  in  1  ALU zero flag.
- w_q  out  8  W accumulator.
- carry_q  out  1  latched carry flag.
- zero_q  out  1  latched zero flag.
- done  out  1  one-cycle pulse when an instruction retires.
- busy  out  1  high in EXEC.

## Operation
- ALU opcodes:
  - 000 ADD; 001 SUB (A-B).
  - 010 AND; 011 OR; 100 XOR.
  - 101 NOT A; 110 INC A; 111 DEC A.
- ALU flag behaviour:
  - Carry is set on ADD/INC overflow and on SUB/DEC borrow; it is 0 for logic ops.
  - Zero is set when the result is 0.
- States: IDLE and EXEC.
- IDLE:
  - instr_ready = !w_load.
  - On instr_valid && instr_ready: latch Wreg_w <= w_q, Rn_w <= rf[instr_rn], ALU_OP <= instr_op, and the wb flag; go to EXEC.
- EXEC:
  - instr_ready = 0 and busy = 1.
  - At the next rising edge: carry_q <= carryF_w and zero_q <= zeroF_w.
  - If wb, w_q <= ALUResult_w.
  - Pulse done for the following cycle and return to IDLE.
- Register file:
  - Written on any cycle when rf_we = 1.
  - Write-through: if rf_we && rf_waddr == instr_rn on the accept edge, Rn_w captures rf_wdata.
- W direct load:
  - Honoured only in IDLE. w_load masks instr_ready, so a load and an accept never coincide.
  - Ignored in EXEC.
- Wreg_w, Rn_w and ALU_OP hold their last values in IDLE.
- All arithmetic is done in the external ALU. The sequencer performs no arithmetic; all widths are 8 bits with no extension.

## Timing
- Reset (asynchronous, rst_n = 0) forces:
  - state = IDLE.
  - w_q, Wreg_w, Rn_w = 0; ALU_OP = 000.
  - carry_q = 0, zero_q = 0, done = 0, busy = 0.
  - All register file entries = 0.
- instr_ready is combinational from state and w_load. It is 1 in IDLE after reset while w_load = 0.
- Latency: accept on edge T0. Result, flags and W are updated on edge T1. done is high in the cycle between T1 and T2.
- Throughput: one instruction per 2 cycles. With instr_valid held high, the next accept occurs on edge T1+1, and instr_ready is 1 again in that cycle.
- The ALU has one full cycle (EXEC) to settle. The sequencer samples ALU outputs only on the EXEC exit edge.
- Reset asserted during EXEC:
  - The instruction is abandoned.
  - No W or flag update; done stays 0.
- Back-to-back dependency: the second instruction sees W as written by the first, because W is updated at T1 and read at the accept edge T1+1.
- Flags are unchanged except on the EXEC exit edge. w_load and rf_we do not affect flags.

## Test plan
- Preload r1 = 5 and w_load 10, then ADD r1 with wb = 1 -> at T1, w_q = 15, carry_q = 0, zero_q = 0; done high for exactly 1 cycle.
- W = 255, r2 = 1, ADD r2 -> w_q = 0, carry_q = 1, zero_q = 1.
- W = 5, r3 = 10, SUB r3 with wb = 0 -> w_q stays 5, carry_q = 1, zero_q = 0. Then W = 10, SUB with wb = 1 -> w_q = 5, carry_q = 0.
- W = 254, two INC instructions with instr_valid held high -> instr_ready is 0 in each EXEC cycle; w_q = 255 (C = 0), then w_q = 0 (C = 1, Z = 1); exactly 2 done pulses 2 cycles apart.
- rf_we to r0 with value 0xAA on the same edge as accepting XOR r0 with W = 0xFF -> Rn_w = 0xAA and w_q = 0x55. Also: w_load held high -> instr_ready = 0 and no accept.
- Assert rst_n = 0 in EXEC after accepting DEC with W = 0 -> w_q = 0, flags = 0, done never pulses, instr_ready = 1 after release.

Source files
------------

// File: rtl/alu_sequencer.sv
// rtl/alu_sequencer.sv - execute-stage controller driving an external combinational ALU
module alu_sequencer #(
    parameter int NREGS  = 4,
    parameter int RIDX_W = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [2:0]        instr_op,
    input  logic [RIDX_W-1:0] instr_rn,
    input  logic              instr_wb,
    input  logic              rf_we,
    input  logic [RIDX_W-1:0] rf_waddr,
    input  logic [7:0]        rf_wdata,
    input  logic              w_load,
    input  logic [7:0]        w_data,
    output logic [7:0]        Wreg_w,
    output logic [7:0]        Rn_w,
    output logic [2:0]        ALU_OP,
    input  logic [7:0]        ALUResult_w,
    input  logic              carryF_w,
    input  logic              zeroF_w,
    output logic [7:0]        w_q,
    output logic              carry_q,
    output logic              zero_q,
    output logic              done,
    output logic              busy
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_EXEC = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  w_d;
    logic [7:0]  wreg_q, wreg_d;
    logic [7:0]  rn_q, rn_d;
    logic [2:0]  op_q, op_d;
    logic        wb_q, wb_d;
    logic        carry_d, zero_d;
    logic        done_q, done_d;
    logic [7:0]  rf_q [NREGS];
    logic [7:0]  rf_d [NREGS];
    logic        accept;

    assign instr_ready = (state_q == S_IDLE) && !w_load;
    assign accept      = instr_valid && instr_ready;
    assign busy        = (state_q == S_EXEC);
    assign done        = done_q;
    assign Wreg_w      = wreg_q;
    assign Rn_w        = rn_q;
    assign ALU_OP      = op_q;

    // Register file next state: any cycle with rf_we writes one entry.
    always_comb begin
        for (int i = 0; i < NREGS; i++) begin
            rf_d[i] = rf_q[i];
        end
        if (rf_we) begin
            rf_d[rf_waddr] = rf_wdata;
        end
    end

    // Sequencer next state: operand capture on accept, W/flag update on EXEC exit.
    always_comb begin
        state_d = state_q;
        w_d     = w_q;
        wreg_d  = wreg_q;
        rn_d    = rn_q;
        op_d    = op_q;
        wb_d    = wb_q;
        carry_d = carry_q;
        zero_d  = zero_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (w_load) begin
                    w_d = w_data;
                end else if (accept) begin
                    wreg_d  = w_q;
                    // Same-edge register write bypasses into the operand latch.
                    rn_d    = (rf_we && (rf_waddr == instr_rn)) ? rf_wdata : rf_q[instr_rn];
                    op_d    = instr_op;
                    wb_d    = instr_wb;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                carry_d = carryF_w;
                zero_d  = zeroF_w;
                if (wb_q) begin
                    w_d = ALUResult_w;
                end
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            w_q     <= 8'h00;
            wreg_q  <= 8'h00;
            rn_q    <= 8'h00;
            op_q    <= 3'b000;
            wb_q    <= 1'b0;
            carry_q <= 1'b0;
            zero_q  <= 1'b0;
            done_q  <= 1'b0;
            for (int i = 0; i < NREGS; i++) begin
                rf_q[i] <= 8'h00;
            end
        end else begin
            state_q <= state_d;
            w_q     <= w_d;
            wreg_q  <= wreg_d;
            rn_q    <= rn_d;
            op_q    <= op_d;
            wb_q    <= wb_d;
            carry_q <= carry_d;
            zero_q  <= zero_d;
            done_q  <= done_d;
            for (int i = 0; i < NREGS; i++) begin
                rf_q[i] <= rf_d[i];
            end
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// tb/tb_alu_sequencer.sv - directed and randomized checks of alu_sequencer against a reference model
module tb_alu_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       instr_valid = 1'b0;
    logic       instr_ready;
    logic [2:0] instr_op = 3'b000;
    logic [1:0] instr_rn = 2'd0;
    logic       instr_wb = 1'b0;
    logic       rf_we = 1'b0;
    logic [1:0] rf_waddr = 2'd0;
    logic [7:0] rf_wdata = 8'h00;
    logic       w_load = 1'b0;
    logic [7:0] w_data = 8'h00;
    logic [7:0] Wreg_w, Rn_w;
    logic [2:0] ALU_OP;
    logic [7:0] ALUResult_w;
    logic       carryF_w, zeroF_w;
    logic [7:0] w_q;
    logic       carry_q, zero_q, done, busy;

    int vectors = 0;
    int miscompares = 0;

    // Reference state of the programmer-visible machine.
    logic [7:0] m_w;
    logic       m_c, m_z;
    logic [7:0] m_rf [4];

    always #5 clk = ~clk;

    alu_sequencer #(.NREGS(4), .RIDX_W(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr_op(instr_op), .instr_rn(instr_rn), .instr_wb(instr_wb),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .w_load(w_load), .w_data(w_data),
        .Wreg_w(Wreg_w), .Rn_w(Rn_w), .ALU_OP(ALU_OP),
        .ALUResult_w(ALUResult_w), .carryF_w(carryF_w), .zeroF_w(zeroF_w),
        .w_q(w_q), .carry_q(carry_q), .zero_q(zero_q),
        .done(done), .busy(busy)
    );

    // Arithmetic meaning of each opcode: {carry, zero, result}.
    function automatic logic [9:0] alu_ref(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        int r;
        logic c;
        c = 1'b0;
        case (op)
            3'd0: begin r = int'(a) + int'(b); c = (r > 255); end
            3'd1: begin r = int'(a) - int'(b); c = (r < 0); end
            3'd2: r = int'(a & b);
            3'd3: r = int'(a | b);
            3'd4: r = int'(a ^ b);
            3'd5: r = int'(~a);
            3'd6: begin r = int'(a) + 1; c = (r > 255); end
            default: begin r = int'(a) - 1; c = (r < 0); end
        endcase
        r = r & 255;
        return {c, (r == 0), r[7:0]};
    endfunction

    // The external combinational ALU.
    always_comb begin
        {carryF_w, zeroF_w, ALUResult_w} = alu_ref(ALU_OP, Wreg_w, Rn_w);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_w = 8'h00; m_c = 1'b0; m_z = 1'b0;
        for (int i = 0; i < 4; i++) m_rf[i] = 8'h00;
    endtask

    task automatic rf_write(input logic [1:0] idx, input logic [7:0] val);
        rf_we = 1'b1; rf_waddr = idx; rf_wdata = val;
        tick();
        rf_we = 1'b0;
        m_rf[idx] = val;
        chk("rf_write_flags_c", {31'd0, carry_q}, {31'd0, m_c});
    endtask

    task automatic load_w(input logic [7:0] val);
        w_load = 1'b1; w_data = val; instr_valid = 1'b1;
        #1;
        chk("wload_masks_ready", {31'd0, instr_ready}, 32'd0);
        tick();
        w_load = 1'b0; instr_valid = 1'b0;
        m_w = val;
        chk("wload_w", {24'd0, w_q}, {24'd0, m_w});
        chk("wload_no_accept", {31'd0, busy}, 32'd0);
    endtask

    // Issue one instruction; optionally write the register file on the accept edge.
    task automatic exec_instr(input logic [2:0] op, input logic [1:0] rn, input logic wb,
                              input logic do_wr, input logic [1:0] wa, input logic [7:0] wd);
        logic [7:0] b_exp;
        logic [9:0] r;
        instr_valid = 1'b1; instr_op = op; instr_rn = rn; instr_wb = wb;
        rf_we = do_wr; rf_waddr = wa; rf_wdata = wd;
        #1;
        chk("ready_idle", {31'd0, instr_ready}, 32'd1);
        b_exp = (do_wr && wa == rn) ? wd : m_rf[rn];
        if (do_wr) m_rf[wa] = wd;
        tick();
        instr_valid = 1'b0; rf_we = 1'b0;
        chk("exec_busy", {31'd0, busy}, 32'd1);
        chk("exec_ready", {31'd0, instr_ready}, 32'd0);
        chk("opa", {24'd0, Wreg_w}, {24'd0, m_w});
        chk("opb", {24'd0, Rn_w}, {24'd0, b_exp});
        chk("aluop", {29'd0, ALU_OP}, {29'd0, op});
        chk("exec_done", {31'd0, done}, 32'd0);
        r = alu_ref(op, m_w, b_exp);
        m_c = r[9]; m_z = r[8];
        if (wb) m_w = r[7:0];
        tick();
        chk("ret_w", {24'd0, w_q}, {24'd0, m_w});
        chk("ret_c", {31'd0, carry_q}, {31'd0, m_c});
        chk("ret_z", {31'd0, zero_q}, {31'd0, m_z});
        chk("ret_done", {31'd0, done}, 32'd1);
        chk("ret_busy", {31'd0, busy}, 32'd0);
        tick();
        chk("done_pulse_end", {31'd0, done}, 32'd0);
    endtask

    initial begin
        model_reset();
        #12;
        chk("rst_w", {24'd0, w_q}, 32'd0);
        chk("rst_opa", {24'd0, Wreg_w}, 32'd0);
        chk("rst_opb", {24'd0, Rn_w}, 32'd0);
        chk("rst_op", {29'd0, ALU_OP}, 32'd0);
        chk("rst_flags", {30'd0, carry_q, zero_q}, 32'd0);
        chk("rst_done_busy", {30'd0, done, busy}, 32'd0);
        rst_n = 1'b1;
        tick();
        chk("rst_ready", {31'd0, instr_ready}, 32'd1);

        // 5 + 10
        rf_write(2'd1, 8'd5);
        load_w(8'd10);
        exec_instr(3'd0, 2'd1, 1'b1, 1'b0, 2'd0, 8'd0);
        chk("add_15", {24'd0, w_q}, 32'd15);

        // 255 + 1 wraps with carry and zero
        load_w(8'd255);
        rf_write(2'd2, 8'd1);
        exec_instr(3'd0, 2'd2, 1'b1, 1'b0, 2'd0, 8'd0);
        chk("add_wrap", {22'd0, w_q, carry_q, zero_q}, {22'd0, 8'd0, 2'b11});

        // compare-only SUB borrows, then real SUB
        load_w(8'd5);
        rf_write(2'd3, 8'd10);
        exec_instr(3'd1, 2'd3, 1'b0, 1'b0, 2'd0, 8'd0);
        chk("cmp_keep_w", {23'd0, w_q, carry_q}, {23'd0, 8'd5, 1'b1});
        load_w(8'd10);
        exec_instr(3'd1, 2'd1, 1'b1, 1'b0, 2'd0, 8'd0);
        chk("sub_5", {23'd0, w_q, carry_q}, {23'd0, 8'd5, 1'b0});

        // back-to-back INC with instr_valid held high
        load_w(8'd254);
        instr_valid = 1'b1; instr_op = 3'd6; instr_rn = 2'd0; instr_wb = 1'b1;
        tick();
        chk("b2b_exec1_ready", {30'd0, instr_ready, busy}, 32'b01);
        tick();
        chk("b2b_ret1", {21'd0, w_q, carry_q, zero_q, done}, {21'd0, 8'd255, 3'b001});
        chk("b2b_ready_again", {31'd0, instr_ready}, 32'd1);
        tick();
        instr_valid = 1'b0;
        chk("b2b_exec2", {29'd0, instr_ready, busy, done}, 32'b010);
        chk("b2b_opa2", {24'd0, Wreg_w}, 32'd255);
        tick();
        chk("b2b_ret2", {21'd0, w_q, carry_q, zero_q, done}, {21'd0, 8'd0, 3'b111});
        tick();
        chk("b2b_done_end", {31'd0, done}, 32'd0);
        m_w = 8'd0; m_c = 1'b1; m_z = 1'b1;

        // write-through on accept edge
        load_w(8'hFF);
        exec_instr(3'd4, 2'd0, 1'b1, 1'b1, 2'd0, 8'hAA);
        chk("xor_55", {24'd0, w_q}, 32'h55);

        // reset during EXEC abandons the instruction
        rf_write(2'd1, 8'd7);
        load_w(8'd0);
        instr_valid = 1'b1; instr_op = 3'd7; instr_rn = 2'd1; instr_wb = 1'b1;
        tick();
        instr_valid = 1'b0;
        chk("rst_exec_busy", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rst_exec_async", {20'd0, w_q, carry_q, zero_q, done, busy}, 32'd0);
        tick();
        chk("rst_exec_no_done", {31'd0, done}, 32'd0);
        rst_n = 1'b1;
        model_reset();
        #1;
        chk("rst_exec_ready", {31'd0, instr_ready}, 32'd1);
        tick();
        chk("rst_exec_hold", {21'd0, w_q, carry_q, zero_q, done}, 32'd0);
        load_w(8'd3);
        exec_instr(3'd0, 2'd1, 1'b1, 1'b0, 2'd0, 8'd0);

        // randomized traffic
        for (int it = 0; it < 60; it++) begin
            case ($urandom_range(0, 3))
                0: rf_write(2'($urandom_range(0, 3)), 8'($urandom));
                1: load_w(8'($urandom));
                default: exec_instr(3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
                                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                                    2'($urandom_range(0, 3)), 8'($urandom));
            endcase
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
